// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_pkg
// Description : Shared definitions for the instruction-fetch slice. Holds the
//               datapath width, the bit positions of the instruction fields,
//               and the opcode encodings.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

  localparam int XLEN = 32;

  // Instruction field positions
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

  typedef enum logic [6:0] {
    OP_LW     = 7'b0000011,
    OP_SW     = 7'b0100011,
    OP_R_TYPE = 7'b0110011,
    OP_BEQ    = 7'b1100011
  } opcode_e;

  function automatic logic [6:0] get_opcode(input logic [XLEN-1:0] inst);
    return inst[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage : instr_fetch_pkg
`default_nettype wire

// File: rtl/instr_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small synchronous FIFO buffering fetched {instruction, pc}
//               pairs. The head entry is visible combinationally on rd_data.
//               flush discards all entries at the next edge.
// Ports       : clk, rst_n       - clock, async active-low reset
//               flush            - drop all stored entries
//               push, wr_data    - write one entry (ignored when full/flush)
//               pop              - remove the head entry (ignored when empty)
//               rd_data          - head entry
//               empty, count     - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2 * XLEN
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_push  = push && (count_q != DEPTH_C) && !flush;
    do_pop   = pop && (count_q != '0);
    if (flush) begin
      // Realign the read side onto the write side; stored data is don't-care.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_next(rd_ptr_q);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch unit. Issues sequential word-aligned fetches
//               with up to DEPTH requests in flight, buffers in-order
//               responses in a DEPTH-entry FIFO and presents them to decode
//               with a valid/ready handshake. A redirect flushes the buffer,
//               retargets the fetch PC and discards all in-flight responses.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               imem_req/addr/gnt           - request channel to memory
//               imem_rvalid/rdata           - in-order response channel
//               redirect, redirect_pc       - taken branch/jump from execute
//               inst_valid/ready/data/pc    - instruction stream to decode
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  // Headroom so the three-way occupancy sum cannot overflow.
  localparam int SW = CW + 2;
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     drop_q, drop_d;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [2*XLEN-1:0] fifo_head;
  logic [SW-1:0]     inflight;
  logic              accept;
  logic              rsp;
  logic              rsp_drop;
  logic              rsp_keep;
  logic              push;
  logic              pop;
  logic [XLEN-1:0]   rsp_pc;

  assign inflight = SW'(fifo_count) + SW'(outst_q) + SW'(drop_q);

  // rst_n gates the request so it is low for the whole reset interval yet
  // rises in the very first cycle after release.
  assign imem_req  = rst_n && !redirect && (inflight < DEPTH_S);
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_gnt;

  // A response with nothing in flight is spurious and ignored. Dropped
  // requests are always older than live ones, so they are retired first.
  assign rsp      = imem_rvalid && ((outst_q != '0) || (drop_q != '0));
  assign rsp_drop = rsp && (drop_q != '0);
  assign rsp_keep = rsp && (drop_q == '0);
  assign push     = rsp_keep && !redirect;
  assign pop      = inst_valid && inst_ready;

  // Live requests are contiguous words ending just below fetch_pc, so the
  // oldest one's address is recovered without storing it.
  assign rsp_pc = fetch_pc_q - XLEN'({outst_q, 2'b00});

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      outst_d    = '0;
      // Everything still in flight, plus any grant this cycle, becomes stale.
      drop_d     = drop_q + outst_q + CW'(accept) - CW'(rsp);
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      outst_d = outst_q + CW'(accept) - CW'(rsp_keep);
      drop_d  = drop_q - CW'(rsp_drop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect),
    .push    (push),
    .wr_data ({imem_rdata, rsp_pc}),
    .pop     (pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign inst_valid = !fifo_empty;
  assign inst_data  = fifo_head[2*XLEN-1:XLEN];
  assign inst_pc    = fifo_head[XLEN-1:0];

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch. A second instance with a
//               near-top reset PC exercises address wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  logic        rst2_n;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_rvalid2;
  logic        inst_valid2;
  logic [31:0] inst_data2;
  logic [31:0] inst_pc2;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst2_n),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(1'b1),
    .imem_rvalid(imem_rvalid2), .imem_rdata(32'h0000_0013),
    .redirect(1'b0), .redirect_pc(32'h0),
    .inst_valid(inst_valid2), .inst_ready(1'b1),
    .inst_data(inst_data2), .inst_pc(inst_pc2)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mk(input logic [31:0] a);
    return {a[24:0], 7'h13};
  endfunction

  // Memory model for dut: grants seen before an edge are answered one cycle later.
  logic [31:0] mq[$];
  bit          mem_hold;
  int          n_grant;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && imem_req === 1'b1 && imem_gnt === 1'b1) begin
      mq.push_back(imem_addr);
      n_grant++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!mem_hold && mq.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mk(mq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  // Memory model and observers for dut2.
  logic [31:0] acc2[$];
  logic [31:0] del2[$];
  bit          g2;

  always @(negedge clk) begin
    g2 = 1'b0;
    if (rst2_n === 1'b1) begin
      if (imem_req2 === 1'b1) begin
        acc2.push_back(imem_addr2);
        g2 = 1'b1;
      end
      if (inst_valid2 === 1'b1) del2.push_back(inst_pc2);
    end
  end

  always @(posedge clk) begin
    #1;
    imem_rvalid2 = g2;
  end

  typedef struct {
    logic        gnt;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vt[13];

  task automatic do_reset(input logic g, input logic r, input bit hold);
    @(negedge clk);
    rst_n      = 1'b0;
    redirect   = 1'b0;
    imem_gnt   = g;
    inst_ready = r;
    mem_hold   = hold;
    mq.delete();
    n_grant    = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bit seen;
    // gnt held low for five cycles, then streaming with a 1-cycle memory.
    vt[0]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
    vt[5]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000};
    vt[8]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0};
    vt[10] = '{1'b1, 1'b1, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008};
    vt[11] = '{1'b1, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C};
    vt[12] = '{1'b1, 1'b1, 1'b1, 32'h0000_0014, 1'b0, 32'h0};

    rst_n = 1'b0; rst2_n = 1'b0;
    imem_gnt = 1'b0; inst_ready = 1'b1;
    redirect = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0; imem_rvalid2 = 1'b0;
    mem_hold = 1'b0; n_grant = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   imem_req,   32'd0);
    chk("rst_valid", inst_valid, 32'd0);
    chk("rst_addr",  imem_addr,  32'h0);
    chk("rst_req2",  imem_req2,  32'd0);
    chk("rst_addr2", imem_addr2, 32'hFFFF_FFF8);

    @(posedge clk);
    #1 rst_n = 1'b1; rst2_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      imem_gnt   = vt[i].gnt;
      inst_ready = vt[i].ready;
      @(negedge clk);
      chk($sformatf("v%0d_req", i),   imem_req,   32'(vt[i].exp_req));
      chk($sformatf("v%0d_addr", i),  imem_addr,  vt[i].exp_addr);
      chk($sformatf("v%0d_valid", i), inst_valid, 32'(vt[i].exp_valid));
      if (vt[i].exp_valid) begin
        chk($sformatf("v%0d_pc", i),   inst_pc,   vt[i].exp_pc);
        chk($sformatf("v%0d_data", i), inst_data, mk(vt[i].exp_pc));
      end
      @(posedge clk);
      #1;
    end

    // Decoder stalled for ten cycles: buffer fills, fetch stops, nothing lost.
    do_reset(1'b1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    chk("stall_grants", n_grant,    32'd2);
    chk("stall_req",    imem_req,   32'd0);
    chk("stall_addr",   imem_addr,  32'h8);
    chk("stall_valid",  inst_valid, 32'd1);
    chk("stall_pc",     inst_pc,    32'h0);
    @(posedge clk);
    #1 inst_ready = 1'b1;
    @(negedge clk);
    chk("drain0_pc",   inst_pc,   32'h0);
    chk("drain0_data", inst_data, mk(32'h0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("drain1_valid", inst_valid, 32'd1);
    chk("drain1_pc",    inst_pc,    32'h4);
    chk("drain1_data",  inst_data,  mk(32'h4));

    // Redirect with two requests in flight.
    do_reset(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 redirect = 1'b1; redirect_pc = 32'h0000_0102;
    @(negedge clk);
    chk("redir_req", imem_req, 32'd0);
    mem_hold = 1'b0;
    @(posedge clk);
    #1 redirect = 1'b0;
    @(negedge clk);
    chk("redir_c1_addr",  imem_addr,  32'h0000_0100);
    chk("redir_c1_req",   imem_req,   32'd0);
    chk("redir_c1_valid", inst_valid, 32'd0);
    @(negedge clk);
    chk("redir_c2_req",   imem_req,   32'd1);
    chk("redir_c2_addr",  imem_addr,  32'h0000_0100);
    chk("redir_c2_valid", inst_valid, 32'd0);
    @(negedge clk);
    chk("redir_c3_valid", inst_valid, 32'd0);
    chk("redir_c3_addr",  imem_addr,  32'h0000_0104);
    @(negedge clk);
    chk("redir_c4_valid", inst_valid, 32'd1);
    chk("redir_c4_pc",    inst_pc,    32'h0000_0100);
    chk("redir_c4_data",  inst_data,  mk(32'h0000_0100));

    // Reset pulse while two requests are outstanding.
    do_reset(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mrst_pre_addr", imem_addr, 32'h8);
    rst_n = 1'b0;
    imem_gnt = 1'b0;
    #1;
    chk("mrst_req",   imem_req,   32'd0);
    chk("mrst_addr",  imem_addr,  32'h0);
    chk("mrst_valid", inst_valid, 32'd0);
    mem_hold = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("stale%0d_valid", i), inst_valid, 32'd0);
    end
    @(posedge clk);
    #1 imem_gnt = 1'b1; inst_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (inst_valid === 1'b1) seen = 1'b1;
    end
    if (seen) begin
      chk("post_rst_pc",   inst_pc,   32'h0);
      chk("post_rst_data", inst_data, mk(32'h0));
    end else begin
      n_total++;
      $display("FAIL post_rst_timeout: got no inst_valid expected inst_valid within 10 cycles");
    end

    // Wrap-around instance.
    chk("wrap_nacc", 32'(acc2.size() >= 3), 32'd1);
    chk("wrap_ndel", 32'(del2.size() >= 3), 32'd1);
    if (acc2.size() >= 3) begin
      chk("wrap_addr0", acc2[0], 32'hFFFF_FFF8);
      chk("wrap_addr1", acc2[1], 32'hFFFF_FFFC);
      chk("wrap_addr2", acc2[2], 32'h0000_0000);
    end
    if (del2.size() >= 3) begin
      chk("wrap_pc0", del2[0], 32'hFFFF_FFF8);
      chk("wrap_pc1", del2[1], 32'hFFFF_FFFC);
      chk("wrap_pc2", del2[2], 32'h0000_0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_instr_fetch
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL expose parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The module SHALL expose parameter DEPTH, default 2, giving the instruction-buffer entries and the maximum outstanding memory requests.
REQ-003 The module SHALL have port clk, input, 1 bit, as its single clock, with all state updated on the rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit, as an asynchronous active-low reset.
REQ-005 The module SHALL have port imem_req, output, 1 bit, as the fetch request to instruction memory.
REQ-006 The module SHALL have port imem_addr, output, 32 bits, as the word-aligned fetch address.
REQ-007 The module SHALL have port imem_gnt, input, 1 bit; imem_req and imem_gnt both high in one cycle accepts the request.
REQ-008 The module SHALL have port imem_rvalid, input, 1 bit, as the in-order response strobe from instruction memory.
REQ-009 The module SHALL have port imem_rdata, input, 32 bits, as the instruction word qualified by imem_rvalid.
REQ-010 The module SHALL have port redirect, input, 1 bit, as the taken-branch/jump pulse from execute.
REQ-011 The module SHALL have port redirect_pc, input, 32 bits, as the target address qualified by redirect.
REQ-012 The module SHALL have port inst_valid, output, 1 bit, to flag an instruction presented to the decoder.
REQ-013 The module SHALL have port inst_ready, input, 1 bit; the decoder consumes an instruction when inst_valid and inst_ready are both high.
REQ-014 The module SHALL have port inst_data, output, 32 bits, as the instruction word; op_code is [6:0], funct3 is [14:12] and funct7 is [31:25].
REQ-015 The module SHALL have port inst_pc, output, 32 bits, as the address of inst_data.

Function
REQ-016 fetch_pc SHALL increment by 4 on every accepted request, wrapping modulo 2^32 (32'hFFFF_FFFC+4=0).
REQ-017 imem_req SHALL be high iff (buffer count + outstanding + pending drops) < DEPTH and redirect is low.
REQ-018 imem_addr SHALL equal fetch_pc, and imem_req/imem_addr SHALL hold stable until imem_gnt, except when a redirect occurs.
REQ-019 Responses SHALL be in order, and each non-dropped imem_rvalid SHALL push {imem_rdata, its request address} into a DEPTH-entry FIFO.
REQ-020 inst_valid SHALL be high whenever the FIFO is non-empty, with inst_data/inst_pc driven from the head entry combinationally (zero-cycle latency from FIFO to outputs).
REQ-021 Push and pop in the same cycle SHALL leave the count unchanged; push SHALL never occur when full, guaranteed by REQ-017.
REQ-022 On redirect, the module SHALL flush the FIFO, load fetch_pc with {redirect_pc[31:2],2'b00} at the next edge, and mark all outstanding requests (including one granted in the same cycle) as drop.
REQ-023 Dropped responses SHALL decrement the drop counter and SHALL NOT enter the FIFO; an imem_rvalid coinciding with redirect SHALL be dropped.
REQ-024 inst_valid SHALL be low in the cycle after a redirect; a pop in the redirect cycle SHALL still be honoured by the decoder.
REQ-025 Counters SHALL be clog2(DEPTH+1) bits wide and SHALL never underflow; imem_rvalid with zero outstanding SHALL be ignored.

Reset
REQ-026 On rst_n low, asynchronously: fetch_pc=RESET_PC, FIFO count=0, outstanding=0, drops=0, inst_valid=0, imem_req=0.
REQ-027 The first imem_req SHALL assert in the first cycle after rst_n deasserts; reset mid-transaction SHALL abandon all in-flight responses.

Structure
REQ-028 A shared package SHALL hold the instruction field slice constants, the opcode enum (LW 7'b0000011, SW 7'b0100011, R_TYPE 7'b0110011, BEQ 7'b1100011), and the XLEN=32 constant.
REQ-029 The buffer SHALL be one sub-module, fetch_fifo (parameterised depth, flush input, sync to clk/rst_n).

Verification
REQ-030 Reset release with imem_gnt=1 and 1-cycle rvalid returning 32'h0000_0013 per address -> addresses 0,4,8 issued and inst_pc 0,4,8 delivered in order.
REQ-031 inst_ready=0 for 10 cycles -> at most 2 requests issued, imem_req low, no data lost; then inst_ready=1 -> both drained in order.
REQ-032 Redirect to 32'h0000_0102 with 2 outstanding -> next imem_addr 32'h0000_0100, both stale responses dropped, first inst_pc 32'h0000_0100.
REQ-033 imem_gnt held low 5 cycles -> imem_req and imem_addr stable throughout.
REQ-034 RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 rst_n pulsed low while 2 requests are outstanding -> all outputs reset immediately and stale rvalids ignored.
